digital_pll_controller_param: RTL

//  Parametrised successor of the digital PLL frequency controller. Measures the osc
//  (reference) period in clock (DCO) cycles, compares it with div and steps a fractional

---
 rtl/digital_pll_controller_param_if.sv | 43 ++++
 rtl/digital_pll_controller_param.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/digital_pll_controller_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : digital_pll_controller_param_if
//  Description : Bundle for the digital PLL controller. Carries the reference
//                oscillator, the enable/target controls and the trim, tval and
//                lock outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface digital_pll_controller_param_if #(
    parameter int TRIM_W = 26,
    parameter int DIV_W  = 5,
    parameter int FRAC_W = 2
);
    localparam int TVAL_W = $clog2(TRIM_W + 1) + FRAC_W;

    logic              osc;
    logic              enable;
    logic [DIV_W-1:0]  div;
    logic [TRIM_W-1:0] trim;
    logic [TVAL_W-1:0] tval;
    logic              locked;

    // Stimulus side: drives the reference and the controls
    modport master (
        output osc,
        output enable,
        output div,
        input  trim,
        input  tval,
        input  locked
    );

    // Controller side
    modport slave (
        input  osc,
        input  enable,
        input  div,
        output trim,
        output tval,
        output locked
    );
endinterface
`default_nettype wire

// File: rtl/digital_pll_controller_param.sv
`default_nettype none
// ============================================================================
//  Module      : digital_pll_controller_param
//  Description : Digital PLL frequency controller. Counts DCO clocks per osc
//                period, compares the count with div and steps a fractional
//                trim accumulator (tval) down when the DCO runs fast and up
//                when it runs slow. A deadband of +/-HYST leaves tval alone
//                and counts toward lock. The integer part of tval drives a
//                thermometer-coded DCO trim word.
//  Revision    : 1.0 - initial release
// ============================================================================
module digital_pll_controller_param #(
    parameter int TRIM_W     = 26,
    parameter int DIV_W      = 5,
    parameter int CNT_W      = 8,
    parameter int FRAC_W     = 2,
    parameter int STEP       = 1,
    parameter int HYST       = 0,
    parameter int PREP_EDGES = 3,
    parameter int LOCK_N     = 4
) (
    input  logic                             clock,
    input  logic                             resetb,
    digital_pll_controller_param_if.slave    bus
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_tval_w = $clog2(TRIM_W + 1) + FRAC_W;
    localparam int c_prep_w = $clog2(PREP_EDGES + 1);
    localparam int c_lock_w = $clog2(LOCK_N + 1);
    // All magnitude comparisons happen at this width so that div+HYST,
    // tval+STEP and the cap can never overflow.
    localparam int c_ew     = 32;

    localparam logic [CNT_W-1:0]    c_cnt_max   = '1;
    localparam logic [c_ew-1:0]     c_cap       = c_ew'(TRIM_W) << FRAC_W;
    localparam logic [c_ew-1:0]     c_step      = c_ew'(STEP);
    localparam logic [c_ew-1:0]     c_hyst      = c_ew'(HYST);
    localparam logic [c_prep_w-1:0] c_prep_last = c_prep_w'(PREP_EDGES);
    localparam logic [c_lock_w-1:0] c_lock_last = c_lock_w'(LOCK_N);

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic                r_osc_s1;
    logic                r_osc_s2;
    logic                r_osc_s3;
    logic                w_osc_rise;

    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_meas;

    logic [c_prep_w-1:0] r_prep;
    logic                w_prep_done;
    logic                w_update;

    logic [c_ew-1:0]     w_meas_e;
    logic [c_ew-1:0]     w_div_e;
    logic [c_ew-1:0]     w_tval_e;
    logic                w_too_fast;
    logic                w_too_slow;
    logic                w_in_band;
    logic [c_ew-1:0]     w_tval_dn;
    logic [c_ew-1:0]     w_tval_up;

    logic [c_tval_w-1:0] r_tval;
    logic [c_lock_w-1:0] r_lock_cnt;
    logic                r_locked;
    logic [TRIM_W-1:0]   w_trim_next;
    logic [TRIM_W-1:0]   r_trim;

    // ------------------------------------------------------------------------
    // Reference edge detection
    // ------------------------------------------------------------------------

    // Two-flop synchroniser for the asynchronous osc, plus a delay flop for
    // rising-edge detection.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_osc_s1 <= 1'b0;
            r_osc_s2 <= 1'b0;
            r_osc_s3 <= 1'b0;
        end else begin
            r_osc_s1 <= bus.osc;
            r_osc_s2 <= r_osc_s1;
            r_osc_s3 <= r_osc_s2;
        end
    end

    assign w_osc_rise = r_osc_s2 & ~r_osc_s3;

    // ------------------------------------------------------------------------
    // Period measurement
    // ------------------------------------------------------------------------

    // The measurement includes the rise cycle itself, so a period of P
    // clocks measures exactly P. Saturation keeps a stalled osc reading as
    // "very slow reference" instead of wrapping to a small value.
    assign w_meas = (r_cnt == c_cnt_max) ? c_cnt_max : r_cnt + 1'b1;

    // Clock counter: restarts on every reference edge, otherwise saturating.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_cnt <= '0;
        end else if (w_osc_rise) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_meas;
        end
    end

    // ------------------------------------------------------------------------
    // Warm-up: the first edges after reset or re-enable only restart the
    // counter, because the period they close is not a full tracked one.
    // ------------------------------------------------------------------------
    assign w_prep_done = (r_prep == c_prep_last);
    assign w_update    = w_osc_rise & bus.enable & w_prep_done;

    // Warm-up edge counter, re-armed whenever tracking is disabled.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_prep <= '0;
        end else if (!bus.enable) begin
            r_prep <= '0;
        end else if (w_osc_rise && !w_prep_done) begin
            r_prep <= r_prep + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Frequency error classification
    // ------------------------------------------------------------------------
    assign w_meas_e = c_ew'(w_meas);
    assign w_div_e  = c_ew'(bus.div);
    assign w_tval_e = c_ew'(r_tval);

    // A high count means many DCO clocks per reference period: DCO too fast.
    // The lower bound only exists when div >= HYST (no unsigned underflow).
    assign w_too_fast = (w_meas_e > w_div_e + c_hyst);
    assign w_too_slow = (w_div_e >= c_hyst) && (w_meas_e < w_div_e - c_hyst);
    assign w_in_band  = ~w_too_fast & ~w_too_slow;

    // Candidate accumulator values, clamped to [0, TRIM_W << FRAC_W].
    assign w_tval_dn = (w_tval_e >= c_step) ? (w_tval_e - c_step) : '0;
    assign w_tval_up = (w_tval_e + c_step >= c_cap) ? c_cap : (w_tval_e + c_step);

    // ------------------------------------------------------------------------
    // Trim accumulator
    // ------------------------------------------------------------------------

    // Step tval once per tracked reference period, holding it inside the band
    // and whenever tracking is disabled.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_tval <= '0;
        end else if (w_update) begin
            if (w_too_fast) begin
                r_tval <= c_tval_w'(w_tval_dn);
            end else if (w_too_slow) begin
                r_tval <= c_tval_w'(w_tval_up);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Lock detection
    // ------------------------------------------------------------------------

    // Count consecutive in-band periods; any correction drops lock on the
    // same edge that moves tval.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (!bus.enable) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (w_update) begin
            if (w_in_band) begin
                if (r_lock_cnt != c_lock_last) begin
                    r_lock_cnt <= r_lock_cnt + 1'b1;
                end
                if (r_lock_cnt + 1'b1 >= c_lock_last) begin
                    r_locked <= 1'b1;
                end
            end else begin
                r_lock_cnt <= '0;
                r_locked   <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Thermometer decode of the integer part of tval
    // ------------------------------------------------------------------------

    // Bit i is set when i is below the integer trim level.
    always_comb begin
        w_trim_next = '0;
        for (int i = 0; i < TRIM_W; i++) begin
            w_trim_next[i] = (c_ew'(i) < (w_tval_e >> FRAC_W));
        end
    end

    // Register the decoded word so the DCO sees a glitch-free trim.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_trim <= '0;
        end else begin
            r_trim <= w_trim_next;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.trim   = r_trim;
    assign bus.tval   = r_tval;
    assign bus.locked = r_locked;

endmodule
`default_nettype wire
